perm_selection_sequencer: RTL

Upstream driver for the safe permutation generator. Produces the 5-bit selection index (0..NUM_PERMS-1) consumed by the generator and holds each index stable for a programmable epoch. Indices come from a wrapping counter (sequential mode) or a rejection-sampled Galois LFSR (random mode). Each new index is offered over a valid/ready handshake to the port-permutation control logic.

---
 rtl/perm_selection_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/perm_selection_sequencer.sv
// Selection-index sequencer for the safe permutation generator: draws an index
// (counter or rejection-sampled LFSR), offers it over valid/ready, then holds it
// for a programmable epoch.
//   state   | meaning
//   IDLE    | parked, selection keeps last value
//   DRAW    | produce a candidate index (random mode may take several cycles)
//   PRESENT | sel_valid high, waiting for sel_ready
//   HOLD    | epoch countdown before the next draw
module perm_selection_sequencer #(
  parameter int PERM_SIZE = 5,
  parameter int NUM_PERMS = 24,
  parameter int EPOCH_W = 16,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1),
  parameter int MAX_REJECT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [EPOCH_W-1:0]   epoch_len,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed_value,
  input  logic                 sel_ready,
  output logic [PERM_SIZE-1:0] selection,
  output logic                 sel_valid,
  output logic                 epoch_start
);

  localparam int RW = (MAX_REJECT < 2) ? 1 : $clog2(MAX_REJECT + 1);
  localparam logic [PERM_SIZE:0]   NUM_P  = (PERM_SIZE + 1)'(NUM_PERMS);
  localparam logic [PERM_SIZE-1:0] LAST_P = PERM_SIZE'(NUM_PERMS - 1);
  localparam logic [RW:0]          MAX_R  = (RW + 1)'(MAX_REJECT);
  localparam logic [LFSR_W-1:0]    POLY   = LFSR_W'(16'hB400);

  if (NUM_PERMS > (1 << PERM_SIZE)) begin : g_bad_num_perms
    $error("NUM_PERMS does not fit in PERM_SIZE bits");
  end
  if (NUM_PERMS < 1 || MAX_REJECT < 1) begin : g_bad_params
    $error("NUM_PERMS and MAX_REJECT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAW    = 2'd1,
    PRESENT = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PERM_SIZE-1:0] sel_d;
  logic                 valid_d;
  logic                 es_d;
  logic [EPOCH_W-1:0]   epoch_cnt, epoch_cnt_d;
  logic [PERM_SIZE-1:0] seq_next, seq_next_d;
  logic [RW-1:0]        reject_cnt, reject_cnt_d;
  logic [LFSR_W-1:0]    lfsr, lfsr_d;
  logic                 mode_q, mode_d;

  logic [PERM_SIZE-1:0] seq_adv;
  logic [PERM_SIZE-1:0] cand;
  logic                 cand_ok;
  logic [RW:0]          rej_inc;
  logic [LFSR_W-1:0]    lfsr_step;
  logic [LFSR_W-1:0]    seed_eff;

  assign seq_adv   = (seq_next == LAST_P) ? '0 : seq_next + PERM_SIZE'(1);
  assign cand      = lfsr[PERM_SIZE-1:0];
  assign cand_ok   = ({1'b0, cand} < NUM_P);
  assign rej_inc   = {1'b0, reject_cnt} + (RW + 1)'(1);
  assign lfsr_step = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? POLY : '0);
  assign seed_eff  = (seed_value == '0) ? SEED : seed_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      selection   <= '0;
      sel_valid   <= 1'b0;
      epoch_start <= 1'b0;
      epoch_cnt   <= '0;
      seq_next    <= '0;
      reject_cnt  <= '0;
      lfsr        <= SEED;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      selection   <= sel_d;
      sel_valid   <= valid_d;
      epoch_start <= es_d;
      epoch_cnt   <= epoch_cnt_d;
      seq_next    <= seq_next_d;
      reject_cnt  <= reject_cnt_d;
      lfsr        <= lfsr_d;
      mode_q      <= mode_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = selection;
    valid_d      = sel_valid;
    es_d         = 1'b0;
    epoch_cnt_d  = epoch_cnt;
    seq_next_d   = seq_next;
    reject_cnt_d = reject_cnt;
    lfsr_d       = lfsr;
    mode_d       = mode_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = DRAW;
          mode_d  = mode;
        end
      end

      DRAW: begin
        if (!mode_q) begin
          sel_d      = seq_next;
          seq_next_d = seq_adv;
          valid_d    = 1'b1;
          state_d    = PRESENT;
        end else begin
          lfsr_d = lfsr_step;
          if (cand_ok) begin
            sel_d        = cand;
            reject_cnt_d = '0;
            valid_d      = 1'b1;
            state_d      = PRESENT;
          end else if (rej_inc >= MAX_R) begin
            // Too many misses in a row: fall back to the counter so the draw is bounded.
            sel_d        = seq_next;
            seq_next_d   = seq_adv;
            reject_cnt_d = '0;
            valid_d      = 1'b1;
            state_d      = PRESENT;
          end else begin
            reject_cnt_d = rej_inc[RW-1:0];
          end
        end
      end

      PRESENT: begin
        if (sel_ready) begin
          valid_d     = 1'b0;
          es_d        = 1'b1;
          epoch_cnt_d = (epoch_len == '0) ? '0 : epoch_len - EPOCH_W'(1);
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (epoch_cnt != '0) begin
          epoch_cnt_d = epoch_cnt - EPOCH_W'(1);
        end else if (enable) begin
          state_d = DRAW;
          mode_d  = mode;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (seed_load) lfsr_d = seed_eff;
  end

endmodule
